// File: rtl/fifo_ram_controller.sv
// FIFO controller for a single-clock dual-port RAM (registered write, combinational read).
// Keeps the pointers, the occupancy count and the full/empty flags, and presents
// first-word-fall-through read data.
module fifo_ram_controller #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned MEM_DEPTH  = 4,
  parameter int unsigned ADDR_WIDTH = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic                  pop,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic [DATA_WIDTH-1:0] ram_q,
  output logic [DATA_WIDTH-1:0] ram_data,
  output logic [ADDR_WIDTH-1:0] ram_write_addr,
  output logic [ADDR_WIDTH-1:0] ram_read_addr,
  output logic                  ram_we,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  full,
  output logic                  empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int unsigned CNT_W = ADDR_WIDTH + 1;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(MEM_DEPTH - 1);
  localparam logic [CNT_W-1:0]      FULL_CNT  = CNT_W'(MEM_DEPTH);

  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic                  overflow_q, overflow_d;
  logic                  underflow_q, underflow_d;
  logic                  push_ok, pop_ok;
  logic                  full_s, empty_s;

  // Flags come from the registered count only.
  assign full_s  = (count_q == FULL_CNT);
  assign empty_s = (count_q == '0);

  // Accept rules: a push into a full FIFO is allowed when a pop frees the head slot.
  assign push_ok = push & (~full_s | pop);
  assign pop_ok  = pop & ~empty_s;

  // Next-state: pointer wrap by explicit compare so non-power-of-2 depths work.
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    overflow_d  = push & ~push_ok;
    underflow_d = pop & ~pop_ok;
    if (push_ok) begin
      wr_ptr_d = (wr_ptr_q == LAST_ADDR) ? '0 : wr_ptr_q + ADDR_WIDTH'(1);
    end
    if (pop_ok) begin
      rd_ptr_d = (rd_ptr_q == LAST_ADDR) ? '0 : rd_ptr_q + ADDR_WIDTH'(1);
    end
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // State register; async reset discards all stored words (RAM is left untouched).
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign ram_data       = data_in;
  assign ram_write_addr = wr_ptr_q;
  assign ram_read_addr  = rd_ptr_q;
  assign ram_we         = push_ok;
  assign data_out       = ram_q;
  assign full           = full_s;
  assign empty          = empty_s;
  assign count          = count_q;
  assign overflow       = overflow_q;
  assign underflow      = underflow_q;

endmodule

// File: tb/tb_fifo_ram_controller.sv
// Bench for fifo_ram_controller: one depth-4 and one depth-3 instance share the
// stimulus; each is checked every cycle against a word-count/queue model.
module tb_fifo_ram_controller;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       push = 1'b0;
  logic       pop = 1'b0;
  logic [7:0] data_in = 8'h00;

  logic [7:0] ram_data_s [2];
  logic [7:0] data_out_s [2];
  logic [7:0] ram_q_s    [2];
  logic [1:0] waddr_s    [2];
  logic [1:0] raddr_s    [2];
  logic       we_s       [2];
  logic       full_s     [2];
  logic       empty_s    [2];
  logic [2:0] cnt_s      [2];
  logic       ovf_s      [2];
  logic       unf_s      [2];

  logic [7:0] ram0 [0:3];
  logic [7:0] ram1 [0:2];

  int tests = 0;
  int fails = 0;

  // model: word k ever pushed is store[k]; occupancy = pushed - popped
  logic [7:0]  store [2][1024];
  int unsigned npush [2] = '{0, 0};
  int unsigned npop  [2] = '{0, 0};
  logic        movf  [2] = '{1'b0, 1'b0};
  logic        munf  [2] = '{1'b0, 1'b0};

  always #5 clk = ~clk;

  fifo_ram_controller #(.DATA_WIDTH(8), .MEM_DEPTH(4)) dut4 (
    .clk(clk), .reset(rst_n), .push(push), .pop(pop), .data_in(data_in),
    .ram_q(ram_q_s[0]), .ram_data(ram_data_s[0]), .ram_write_addr(waddr_s[0]),
    .ram_read_addr(raddr_s[0]), .ram_we(we_s[0]), .data_out(data_out_s[0]),
    .full(full_s[0]), .empty(empty_s[0]), .count(cnt_s[0]),
    .overflow(ovf_s[0]), .underflow(unf_s[0])
  );

  fifo_ram_controller #(.DATA_WIDTH(8), .MEM_DEPTH(3)) dut3 (
    .clk(clk), .reset(rst_n), .push(push), .pop(pop), .data_in(data_in),
    .ram_q(ram_q_s[1]), .ram_data(ram_data_s[1]), .ram_write_addr(waddr_s[1]),
    .ram_read_addr(raddr_s[1]), .ram_we(we_s[1]), .data_out(data_out_s[1]),
    .full(full_s[1]), .empty(empty_s[1]), .count(cnt_s[1]),
    .overflow(ovf_s[1]), .underflow(unf_s[1])
  );

  // RAMs: registered write, combinational read
  always @(posedge clk) begin
    if (we_s[0] === 1'b1) ram0[waddr_s[0]] <= ram_data_s[0];
    if (we_s[1] === 1'b1 && waddr_s[1] < 2'd3) ram1[waddr_s[1]] <= ram_data_s[1];
  end
  assign ram_q_s[0] = ram0[raddr_s[0]];
  assign ram_q_s[1] = (raddr_s[1] < 2'd3) ? ram1[raddr_s[1]] : 8'hxx;

  function automatic int dep(input int i);
    return (i == 0) ? 4 : 3;
  endfunction

  function automatic void chk(input string name, input int inst,
                              input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s (depth %0d) at %0t: got %0h expected %0h", name, dep(inst), $time, act, exp);
    end
  endfunction

  // Reference model update from the accept rules
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        npush[i] = 0; npop[i] = 0; movf[i] = 1'b0; munf[i] = 1'b0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        int  occ;
        bit  pok, qok;
        occ = int'(npush[i] - npop[i]);
        pok = push && (occ < dep(i) || pop);
        qok = pop && (occ > 0);
        if (pok) begin
          store[i][npush[i] % 1024] = data_in;
          npush[i]++;
        end
        if (qok) npop[i]++;
        movf[i] = push && !pok;
        munf[i] = pop && !qok;
      end
    end
  end

  // Per-cycle comparison of every output against the model
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      int occ;
      occ = int'(npush[i] - npop[i]);
      chk("count", i, 32'(cnt_s[i]), 32'(occ));
      chk("empty", i, 32'(empty_s[i]), 32'(occ == 0));
      chk("full", i, 32'(full_s[i]), 32'(occ == dep(i)));
      chk("overflow", i, 32'(ovf_s[i]), 32'(movf[i]));
      chk("underflow", i, 32'(unf_s[i]), 32'(munf[i]));
      chk("ram_we", i, 32'(we_s[i]), 32'(push && (occ < dep(i) || pop)));
      chk("ram_write_addr", i, 32'(waddr_s[i]), 32'(npush[i] % dep(i)));
      chk("ram_read_addr", i, 32'(raddr_s[i]), 32'(npop[i] % dep(i)));
      chk("ram_data", i, 32'(ram_data_s[i]), 32'(data_in));
      if (occ > 0) chk("data_out", i, 32'(data_out_s[i]), 32'(store[i][npop[i] % 1024]));
    end
    chk("depth3 addr range", 1, 32'(waddr_s[1] < 2'd3 && raddr_s[1] < 2'd3), 32'd1);
  end

  task automatic drive(input bit p, input bit q, input logic [7:0] d);
    @(posedge clk);
    #1;
    push = p; pop = q; data_in = d;
  endtask

  task automatic look();
    @(negedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] seq [4];
    logic [7:0] exp5 [4];
    seq  = '{8'h11, 8'h22, 8'h33, 8'h44};
    exp5 = '{8'hA2, 8'hA3, 8'hA4, 8'hAA};

    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // idle after reset
    drive(0, 0, 8'h00); drive(0, 0, 8'h00); look();
    chk("lit reset empty", 0, 32'(empty_s[0]), 32'd1);
    chk("lit reset full", 0, 32'(full_s[0]), 32'd0);
    chk("lit reset count", 0, 32'(cnt_s[0]), 32'd0);
    chk("lit reset we", 0, 32'(we_s[0]), 32'd0);
    chk("lit reset ovf/unf", 0, 32'({ovf_s[0], unf_s[0]}), 32'd0);

    // fill, then rejected push
    for (int k = 0; k < 4; k++) drive(1, 0, seq[k]);
    drive(1, 0, 8'h55); look();
    chk("lit push-when-full we", 0, 32'(we_s[0]), 32'd0);
    drive(0, 0, 8'h00); look();
    chk("lit overflow pulse", 0, 32'(ovf_s[0]), 32'd1);
    chk("lit full count", 0, 32'(cnt_s[0]), 32'd4);
    chk("lit full flag", 0, 32'(full_s[0]), 32'd1);
    drive(0, 0, 8'h00); look();
    chk("lit overflow one cycle", 0, 32'(ovf_s[0]), 32'd0);

    // drain in order, then rejected pop
    for (int k = 0; k < 4; k++) begin
      drive(0, 1, 8'h00); look();
      chk("lit pop order", 0, 32'(data_out_s[0]), 32'(seq[k]));
    end
    drive(0, 0, 8'h00); look();
    chk("lit drained empty", 0, 32'(empty_s[0]), 32'd1);
    drive(0, 1, 8'h00); drive(0, 0, 8'h00); look();
    chk("lit underflow pulse", 0, 32'(unf_s[0]), 32'd1);
    chk("lit underflow count", 0, 32'(cnt_s[0]), 32'd0);

    // interleaved with one word in flight: pointers wrap
    drive(1, 0, 8'h60);
    for (int k = 1; k < 6; k++) drive(1, 1, 8'(8'h60 + k));
    drive(0, 1, 8'h00);
    drive(0, 0, 8'h00); look();
    chk("lit wrap wr addr", 0, 32'(waddr_s[0]), 32'd2);
    chk("lit wrap rd addr", 0, 32'(raddr_s[0]), 32'd2);

    // full with simultaneous push and pop
    for (int k = 0; k < 4; k++) drive(1, 0, 8'(8'hA1 + k));
    drive(1, 1, 8'hAA); look();
    chk("lit full push+pop head", 0, 32'(data_out_s[0]), 32'hA1);
    drive(0, 0, 8'h00); look();
    chk("lit full push+pop count", 0, 32'(cnt_s[0]), 32'd4);
    for (int k = 0; k < 4; k++) begin
      drive(0, 1, 8'h00); look();
      chk("lit full push+pop order", 0, 32'(data_out_s[0]), 32'(exp5[k]));
    end

    // empty with simultaneous push and pop, then async reset mid-fill
    drive(1, 1, 8'h5C); drive(1, 0, 8'h5D); look();
    chk("lit empty push+pop count", 0, 32'(cnt_s[0]), 32'd1);
    chk("lit empty push+pop underflow", 0, 32'(unf_s[0]), 32'd1);
    drive(0, 0, 8'h00); look();
    chk("lit mid-fill count", 0, 32'(cnt_s[0]), 32'd2);
    rst_n = 1'b0;
    #1;
    chk("lit async reset empty", 0, 32'(empty_s[0]), 32'd1);
    chk("lit async reset count", 0, 32'(cnt_s[0]), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // randomized traffic with phases biased toward filling and draining
    for (int ph = 0; ph < 8; ph++) begin
      int pp, qp;
      pp = (ph % 2 == 0) ? 75 : 35;
      qp = (ph % 2 == 0) ? 35 : 75;
      for (int c = 0; c < 60; c++) begin
        drive(($urandom_range(99) < pp), ($urandom_range(99) < qp), 8'($urandom));
      end
    end
    drive(0, 0, 8'h00);
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
